// File: rtl/tow_referee.sv
// tow_referee: Tug of War game sequencer.
// Conditions both player keys, arbitrates simultaneous presses, moves one lit
// LED across a 9-LED field, scores round wins and declares the match winner.
// Optional feature macro: TOW_CPU_PLAYER_EN (LFSR-driven CPU right player).
module tow_referee #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int MAX_SCORE   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_l,
    input  logic       key_r,
`ifdef TOW_CPU_PLAYER_EN
    input  logic       tick,
    input  logic [2:0] cpu_level,
`endif
    output logic [8:0] led,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [1:0] round_win,
    output logic       match_over,
    output logic       winner_l
);

    // state      | meaning
    // S_PLAY     | field lit, presses move the LED
    // S_HOLD     | field dark after a round win, counting to recentre
    // S_MATCH    | a player reached MAX_SCORE, everything frozen until reset
    typedef enum logic [1:0] {S_PLAY = 2'd0, S_HOLD = 2'd1, S_MATCH = 2'd2} state_t;

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    SCORE_PRE = 3'(MAX_SCORE - 1);
    localparam logic [3:0]    POS_CTR   = 4'd4;

    state_t        state, state_nxt;
    logic [3:0]    pos;
    logic [CW-1:0] hold_cnt;

    logic l_s1, l_s2, l_prev;
    logic press_l, press_r;

    // left key: 2-FF synchronizer plus previous-value register for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_s1   <= 1'b0;
            l_s2   <= 1'b0;
            l_prev <= 1'b0;
        end else begin
            l_s1   <= key_l;
            l_s2   <= l_s1;
            l_prev <= l_s2;
        end
    end

    assign press_l = l_s2 & ~l_prev;

`ifdef TOW_CPU_PLAYER_EN
    logic [9:0] lfsr;
    logic       cpu_press;

    // CPU player: free-running x^10+x^7+1 LFSR, press registered once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= 10'h001;
            cpu_press <= 1'b0;
        end else begin
            lfsr      <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            cpu_press <= tick & (lfsr[2:0] < cpu_level);
        end
    end

    assign press_r = cpu_press;
`else
    logic r_s1, r_s2, r_prev;

    // right key: 2-FF synchronizer plus previous-value register for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= key_r;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign press_r = r_s2 & ~r_prev;
`endif

    // simultaneous presses cancel; moves and wins only count while playing
    logic mv_l, mv_r, win_l, win_r;
    assign mv_l  = (state == S_PLAY) & press_l & ~press_r;
    assign mv_r  = (state == S_PLAY) & press_r & ~press_l;
    assign win_l = mv_l & (pos == 4'd8);
    assign win_r = mv_r & (pos == 4'd0);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_PLAY;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_PLAY: begin
                if (win_l)      state_nxt = (score_l == SCORE_PRE) ? S_MATCH : S_HOLD;
                else if (win_r) state_nxt = (score_r == SCORE_PRE) ? S_MATCH : S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = S_PLAY;
            end
            S_MATCH: state_nxt = S_MATCH;
            default: state_nxt = S_PLAY;
        endcase
    end

    // datapath: position, hold timer, scores, win pulse and winner flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos       <= POS_CTR;
            hold_cnt  <= '0;
            score_l   <= 3'd0;
            score_r   <= 3'd0;
            round_win <= 2'b00;
            winner_l  <= 1'b0;
        end else begin
            round_win <= {win_l, win_r};
            if (win_l) begin
                score_l <= score_l + 3'd1;
                pos     <= POS_CTR;
                if (score_l == SCORE_PRE) winner_l <= 1'b1;
            end else if (win_r) begin
                score_r <= score_r + 3'd1;
                pos     <= POS_CTR;
            end else if (mv_l) begin
                pos <= pos + 4'd1;
            end else if (mv_r) begin
                pos <= pos - 4'd1;
            end

            if (state == S_HOLD) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= '0;
                    pos      <= POS_CTR;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // outputs: field is lit only while playing
    always_comb begin
        led        = 9'b0;
        match_over = 1'b0;
        case (state)
            S_PLAY:  led = 9'(9'b1 << pos);
            S_MATCH: match_over = 1'b1;
            default: led = 9'b0;
        endcase
    end

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee with HOLD_CYCLES=4, MAX_SCORE=2.
module tb_tow_referee;

    localparam logic [8:0] CTR = 9'b000010000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_l = 1'b0;
    logic       key_r = 1'b0;
    logic [8:0] led;
    logic [2:0] score_l, score_r;
    logic [1:0] round_win;
    logic       match_over, winner_l;
`ifdef TOW_CPU_PLAYER_EN
    logic       tick = 1'b0;
    logic [2:0] cpu_level = 3'd0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tow_referee #(.HOLD_CYCLES(4), .MAX_SCORE(2)) dut (
        .clk(clk),
        .reset(reset),
        .key_l(key_l),
        .key_r(key_r),
`ifdef TOW_CPU_PLAYER_EN
        .tick(tick),
        .cpu_level(cpu_level),
`endif
        .led(led),
        .score_l(score_l),
        .score_r(score_r),
        .round_win(round_win),
        .match_over(match_over),
        .winner_l(winner_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one-cycle key pulse, then three quiet cycles; collects any round_win seen
    task automatic press(input logic l, input logic r, inout logic [1:0] rw);
        key_l = l;
        key_r = r;
        cyc();
        rw = rw | round_win;
        key_l = 1'b0;
        key_r = 1'b0;
        repeat (3) begin
            cyc();
            rw = rw | round_win;
        end
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic mid_reset_check(input string tag);
        #3 reset = 1'b1;
        #1;
        chk({tag, "_led"}, 32'(led), 32'(CTR));
        chk({tag, "_scl"}, 32'(score_l), 32'd0);
        chk({tag, "_scr"}, 32'(score_r), 32'd0);
        chk({tag, "_mo"}, 32'(match_over), 32'd0);
        #2 reset = 1'b0;
        cyc();
    endtask

    initial begin
        logic [1:0] rw;
        bit         won;

        #12;
        chk("rst_led", 32'(led), 32'(CTR));
        chk("rst_scl", 32'(score_l), 32'd0);
        chk("rst_scr", 32'(score_r), 32'd0);
        chk("rst_rw", 32'(round_win), 32'd0);
        chk("rst_mo", 32'(match_over), 32'd0);
        chk("rst_win", 32'(winner_l), 32'd0);
        #1 reset = 1'b0;
        repeat (5) cyc();
        chk("idle_led", 32'(led), 32'(CTR));

`ifdef TOW_CPU_PLAYER_EN
        cpu_level = 3'd7;
        tick = 1'b1;
        won = 1'b0;
        for (int i = 0; i < 60 && !won; i++) begin
            cyc();
            if (score_r == 3'd1) won = 1'b1;
        end
        chk("cpu_win", 32'(won), 32'd1);
        chk("cpu_scl", 32'(score_l), 32'd0);
        mid_reset_check("cpu_rst");
        cpu_level = 3'd0;
        won = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (led != CTR) won = 1'b1;
        end
        chk("cpu_off", 32'(won), 32'd0);
`else
        // latency: sampled at E0, visible after E2
        key_l = 1'b1;
        cyc();
        chk("lat_e0", 32'(led), 32'(CTR));
        key_l = 1'b0;
        cyc();
        chk("lat_e1", 32'(led), 32'(CTR));
        cyc();
        chk("lat_e2", 32'(led), 32'h020);

        // held key moves exactly once
        key_l = 1'b1;
        repeat (10) cyc();
        key_l = 1'b0;
        repeat (4) cyc();
        chk("held_once", 32'(led), 32'h040);

        rw = 2'b00;
        press(1'b0, 1'b1, rw);
        press(1'b0, 1'b1, rw);
        chk("back_ctr", 32'(led), 32'(CTR));

        // simultaneous presses cancel
        rw = 2'b00;
        press(1'b1, 1'b1, rw);
        chk("simul_led", 32'(led), 32'(CTR));
        chk("simul_rw", 32'(rw), 32'd0);

        // walk to the left edge, then win
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, rw);
        chk("left_edge", 32'(led), 32'h100);
        chk("edge_scl", 32'(score_l), 32'd0);
        key_l = 1'b1;
        cyc();
        key_l = 1'b0;
        cyc();
        chk("pre_win_rw", 32'(round_win), 32'd0);
        cyc();
        chk("win_rw", 32'(round_win), 32'h2);
        chk("win_scl", 32'(score_l), 32'd1);
        chk("win_led", 32'(led), 32'd0);
        chk("win_mo", 32'(match_over), 32'd0);
        cyc();
        chk("win_rw_end", 32'(round_win), 32'd0);
        chk("hold_led1", 32'(led), 32'd0);
        cyc();
        cyc();
        chk("hold_led3", 32'(led), 32'd0);
        cyc();
        chk("recentre", 32'(led), 32'(CTR));

        // second left win ends the match
        rw = 2'b00;
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, rw);
        chk("m_rw", 32'(rw), 32'h2);
        chk("m_scl", 32'(score_l), 32'd2);
        chk("m_mo", 32'(match_over), 32'd1);
        chk("m_win", 32'(winner_l), 32'd1);
        chk("m_led", 32'(led), 32'd0);

        // frozen after match over
        rw = 2'b00;
        press(1'b1, 1'b0, rw);
        press(1'b0, 1'b1, rw);
        press(1'b0, 1'b1, rw);
        repeat (6) cyc();
        chk("frz_scl", 32'(score_l), 32'd2);
        chk("frz_scr", 32'(score_r), 32'd0);
        chk("frz_led", 32'(led), 32'd0);
        chk("frz_mo", 32'(match_over), 32'd1);
        chk("frz_win", 32'(winner_l), 32'd1);
        chk("frz_rw", 32'(rw), 32'd0);
        mid_reset_check("mrst");
        chk("mrst_win", 32'(winner_l), 32'd0);

        // right win, then reset during hold
        rw = 2'b00;
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1, rw);
        chk("r_rw", 32'(rw), 32'h1);
        chk("r_scr", 32'(score_r), 32'd1);
        chk("r_scl", 32'(score_l), 32'd0);
        chk("r_led", 32'(led), 32'd0);
        chk("r_win", 32'(winner_l), 32'd0);
        mid_reset_check("hrst");
        repeat (3) cyc();
        chk("hrst_led", 32'(led), 32'(CTR));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
